mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 27 ++
 rtl/mem_access_unit_align.sv | 66 ++++++
 rtl/mem_access_unit.sv | 129 ++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared RV32I types used by the memory access unit and its lane aligner.
package rv32i_types;

    typedef logic [31:0] rv32i_word;
    typedef logic [3:0]  rv32i_mem_wmask;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } mau_state_t;

endpackage

// File: rtl/mem_access_unit_align.sv
// Byte-lane shifting/masking for stores and extraction/extension for loads.
// MEM_ACCESS_MISALIGN_TRAP_EN flags misaligned half/word accesses as bad.
module mem_align
    import rv32i_types::*;
(
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_mask,
    output logic [31:0] o_rdata,
    output logic        o_bad
);

    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_size  = i_funct3[1:0];
        w_off   = i_offset;
        o_wdata = '0;
        o_mask  = '0;
        o_rdata = '0;
        w_byte  = '0;
        w_half  = '0;

        if (i_is_store)
            o_bad = i_funct3[2] | (i_funct3[1:0] == 2'b11);
        else
            o_bad = (i_funct3[1:0] == 2'b11) | (i_funct3 == 3'b110);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        if ((w_size == 2'b01 && i_offset[0]) || (w_size == 2'b10 && i_offset != 2'b00))
            o_bad = 1'b1;
`endif

        // Without the trap, misaligned halves/words fall back to natural alignment.
        case (w_size)
            2'b00:   w_off = i_offset;
            2'b01:   w_off = {i_offset[1], 1'b0};
            default: w_off = 2'b00;
        endcase

        o_wdata = i_wdata << {w_off, 3'b000};
        case (w_size)
            2'b00:   o_mask = 4'b0001 << w_off;
            2'b01:   o_mask = 4'b0011 << w_off;
            default: o_mask = 4'b1111;
        endcase

        w_byte = i_rdata[{w_off, 3'b000} +: 8];
        w_half = i_rdata[{w_off[1], 4'b0000} +: 16];
        case (i_funct3)
            lb:      o_rdata = {{24{w_byte[7]}}, w_byte};
            lbu:     o_rdata = {24'b0, w_byte};
            lh:      o_rdata = {{16{w_half[15]}}, w_half};
            lhu:     o_rdata = {16'b0, w_half};
            lw:      o_rdata = i_rdata;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the datapath and a handshaked memory port, with
// a response watchdog. MEM_ACCESS_MISALIGN_TRAP_EN turns misalignment into an error.
module mem_access_unit
    import rv32i_types::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // Timeout fires on the cycle the counter would step onto all-ones.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    mau_state_t           r_state, w_next;
    logic                 r_is_store;
    logic [2:0]           r_funct3;
    rv32i_word            r_addr, r_wdata, r_rdata;
    logic                 r_err;
    logic [TIMEOUT_W-1:0] r_cnt;

    logic                 w_accept, w_bad, w_sel_store;
    logic [2:0]           w_sel_funct3;
    logic [1:0]           w_sel_off;
    rv32i_word            w_wdata, w_ldata;
    rv32i_mem_wmask       w_mask;

    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_sel_store  = (r_state == IDLE) ? req_is_store  : r_is_store;
    assign w_sel_funct3 = (r_state == IDLE) ? req_funct3    : r_funct3;
    assign w_sel_off    = (r_state == IDLE) ? req_addr[1:0] : r_addr[1:0];

    mem_align u_align (
        .i_is_store (w_sel_store),
        .i_funct3   (w_sel_funct3),
        .i_offset   (w_sel_off),
        .i_wdata    (r_wdata),
        .i_rdata    (r_rdata),
        .o_wdata    (w_wdata),
        .o_mask     (w_mask),
        .o_rdata    (w_ldata),
        .o_bad      (w_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_is_store <= req_is_store;
            r_funct3   <= req_funct3;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rdata    <= '0;
            r_err      <= w_bad;
            r_cnt      <= '0;
        end else if (r_state == ACCESS) begin
            if (mem_resp) begin
                r_rdata <= mem_rdata;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        req_ready       = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        rsp_valid       = 1'b0;
        rsp_rdata       = '0;
        rsp_err         = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = w_bad ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_read    = !r_is_store;
                mem_write   = r_is_store;
                mem_address = {r_addr[31:2], 2'b00};
                if (r_is_store) begin
                    mem_wdata       = w_wdata;
                    mem_byte_enable = w_mask;
                end
                if (mem_resp || r_cnt == CNT_LAST) w_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = r_err;
                if (!r_err && !r_is_store) rsp_rdata = w_ldata;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT_W=4) with a response scoreboard.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   acc_edge = 0;

    mem_access_unit #(.TIMEOUT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Latency counts the acceptance cycle as cycle 1.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_rsp observed=1 expected=0");
            end
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                check("rsp_latency", 32'(edge_n - acc_edge + 2), 32'(e.lat));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic expect_rsp(input logic [31:0] rd, input logic err, input int lat);
        exp_t e;
        e.rdata = rd; e.err = err; e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        while (!req_ready && n < 50) begin tick(1); n++; end
        check("req_ready_before_send", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        tick(1);
        acc_edge  = edge_n;
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd);
        mem_resp = 1'b1; mem_rdata = rd;
        tick(1);
        mem_resp = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        int n;
        // Reset state
        #2;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // lb 0x1003, mem_resp in first ACCESS cycle
        expect_rsp(32'hFFFF_FF80, 1'b0, 3);
        send(1'b0, 3'b000, 32'h0000_1003, '0);
        check("lb_mem_read", {31'b0, mem_read}, 32'd1);
        check("lb_mem_address", mem_address, 32'h0000_1000);
        check("lb_req_ready_busy", {31'b0, req_ready}, 32'd0);
        respond(32'h80FF_FF7F);
        check("lb_strobe_dropped", {31'b0, mem_read}, 32'd0);
        tick(1);

        // sh 0x2002, memory stalls: mem_resp in the fifth ACCESS cycle
        expect_rsp(32'h0, 1'b0, 7);
        send(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF);
        for (int k = 1; k <= 5; k++) begin
            check("sh_mem_write", {31'b0, mem_write}, 32'd1);
            check("sh_byte_enable", {28'b0, mem_byte_enable}, 32'hC);
            check("sh_mem_wdata", mem_wdata, 32'hBEEF_0000);
            check("sh_mem_address", mem_address, 32'h0000_2000);
            if (k == 5) respond(32'h0);
            else tick(1);
        end
        check("sh_write_dropped", {31'b0, mem_write}, 32'd0);
        tick(1);

        // sb 0x5001
        expect_rsp(32'h0, 1'b0, 3);
        send(1'b1, 3'b000, 32'h0000_5001, 32'h0000_00AB);
        check("sb_byte_enable", {28'b0, mem_byte_enable}, 32'h2);
        check("sb_mem_wdata", mem_wdata, 32'h0000_AB00);
        respond(32'h0);
        tick(1);

        // lh 0x4002 sign-extends the upper half
        expect_rsp(32'hFFFF_8001, 1'b0, 3);
        send(1'b0, 3'b001, 32'h0000_4002, '0);
        respond(32'h8001_1234);
        tick(1);

        // lhu 0x3001 (misaligned)
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        expect_rsp(32'h0, 1'b1, 2);
        send(1'b0, 3'b101, 32'h0000_3001, '0);
        check("lhu_mis_no_read", {31'b0, mem_read}, 32'd0);
        tick(1);
`else
        expect_rsp(32'h0000_A678, 1'b0, 3);
        send(1'b0, 3'b101, 32'h0000_3001, '0);
        check("lhu_mis_read", {31'b0, mem_read}, 32'd1);
        check("lhu_mis_address", mem_address, 32'h0000_3000);
        respond(32'h1234_A678);
`endif
        tick(1);

        // Undefined load funct3 110 and store funct3 011
        expect_rsp(32'h0, 1'b1, 2);
        send(1'b0, 3'b110, 32'h0000_1000, '0);
        check("bad_ld_no_read", {31'b0, mem_read}, 32'd0);
        check("bad_ld_no_write", {31'b0, mem_write}, 32'd0);
        tick(1);
        expect_rsp(32'h0, 1'b1, 2);
        send(1'b1, 3'b011, 32'h0000_1000, 32'h1234_5678);
        check("bad_st_no_write", {31'b0, mem_write}, 32'd0);
        tick(1);

        // Timeout: 15 ACCESS cycles, then error response
        expect_rsp(32'h0, 1'b1, 17);
        send(1'b0, 3'b010, 32'h0000_7000, '0);
        for (int k = 1; k <= 15; k++) begin
            check("to_read_held", {31'b0, mem_read}, 32'd1);
            tick(1);
        end
        check("to_read_dropped", {31'b0, mem_read}, 32'd0);
        tick(1);

        // mem_resp on the last possible cycle beats the timeout
        expect_rsp(32'h0BAD_F00D, 1'b0, 17);
        send(1'b0, 3'b010, 32'h0000_7004, '0);
        tick(14);
        check("prio_read_held", {31'b0, mem_read}, 32'd1);
        respond(32'h0BAD_F00D);
        tick(1);

        // mem_resp outside ACCESS is ignored
        mem_resp = 1'b1;
        tick(1);
        mem_resp = 1'b0;
        check("idle_resp_ready", {31'b0, req_ready}, 32'd1);
        check("idle_resp_no_read", {31'b0, mem_read}, 32'd0);

        // Reset mid-ACCESS aborts the load without a response
        send(1'b0, 3'b010, 32'h0000_8000, '0);
        tick(2);
        check("abort_read_before", {31'b0, mem_read}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_read_async", {31'b0, mem_read}, 32'd0);
        check("abort_ready_async", {31'b0, req_ready}, 32'd1);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        expect_rsp(32'hCAFE_BABE, 1'b0, 3);
        send(1'b0, 3'b010, 32'h0000_8004, '0);
        check("post_rst_address", mem_address, 32'h0000_8004);
        respond(32'hCAFE_BABE);

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin tick(1); n++; end
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
